// File: rtl/spmv_iter_sequencer.sv
// Multi-iteration launch/wait/swap/rewind sequencer for a bank of lock-step SpMV kernels.
// Optional per-iteration watchdog is built only when SPMV_ITER_TIMEOUT_EN is defined.
module spmv_iter_sequencer #(
  parameter int unsigned NUM_KERNELS    = 4,
  parameter int unsigned ITER_W         = 16,
  parameter logic        PING_INIT      = 1'b0,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ITER_W-1:0]      num_iters,
  input  logic                   abort,
  input  logic                   cfg_en,
  output logic                   busy,
  output logic                   done,
  output logic [ITER_W-1:0]      iter_cnt,
  output logic                   ping,
  output logic                   rewind,
  output logic [NUM_KERNELS-1:0] k_en,
  input  logic [NUM_KERNELS-1:0] k_done,
  output logic                   timeout
);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, SETTLE, FINISH} state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  if (NUM_KERNELS == 0 || SETTLE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("spmv_iter_sequencer: NUM_KERNELS, SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  state_t                 state_q, state_d;
  logic [ITER_W-1:0]      n_q, n_d;
  logic [ITER_W-1:0]      iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0]      iter_inc;
  logic                   ping_q, ping_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rewind_q, rewind_d;
  logic                   timeout_q, timeout_d;
  logic [NUM_KERNELS-1:0] k_en_q, k_en_d;
  logic [NUM_KERNELS-1:0] done_seen_q, done_seen_d;
  logic [NUM_KERNELS-1:0] lane_done;
  logic [SW-1:0]          settle_q, settle_d;

`ifdef SPMV_ITER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // A lane counts as finished if it was seen earlier this iteration or reports now.
  for (genvar gi = 0; gi < NUM_KERNELS; gi++) begin : g_lane
    assign lane_done[gi] = done_seen_q[gi] | k_done[gi];
  end

  assign iter_inc = iter_cnt_q + ITER_W'(1);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    iter_cnt_d  = iter_cnt_q;
    ping_d      = ping_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rewind_d    = 1'b0;
    timeout_d   = timeout_q;
    k_en_d      = k_en_q;
    done_seen_d = done_seen_q;
    settle_d    = settle_q;
`ifdef SPMV_ITER_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !cfg_en) begin
          iter_cnt_d = '0;
          timeout_d  = 1'b0;
          if (num_iters == '0) begin
            done_d = 1'b1;
          end else begin
            n_d         = num_iters;
            ping_d      = PING_INIT;
            busy_d      = 1'b1;
            rewind_d    = 1'b1;
            k_en_d      = '1;
            done_seen_d = '0;
            state_d     = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_d = RUN;
`ifdef SPMV_ITER_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      RUN: begin
        done_seen_d = lane_done;
        k_en_d      = k_en_q & ~k_done;
`ifdef SPMV_ITER_TIMEOUT_EN
        wd_d        = wd_q + WD_W'(1);
`endif
        if (&lane_done) begin
          iter_cnt_d = iter_inc;
          ping_d     = ~ping_q;
          k_en_d     = '0;
          settle_d   = '0;
          state_d    = (iter_inc == n_q) ? FINISH : SETTLE;
        end
`ifdef SPMV_ITER_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          k_en_d    = '0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
`endif
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          rewind_d    = 1'b1;
          k_en_d      = '1;
          done_seen_d = '0;
          state_d     = LAUNCH;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over anything the active state decided this cycle.
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      rewind_d   = 1'b0;
      k_en_d     = '0;
      iter_cnt_d = iter_cnt_q;
      ping_d     = ping_q;
      timeout_d  = timeout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      iter_cnt_q  <= '0;
      ping_q      <= PING_INIT;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rewind_q    <= 1'b0;
      timeout_q   <= 1'b0;
      k_en_q      <= '0;
      done_seen_q <= '0;
      settle_q    <= '0;
`ifdef SPMV_ITER_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      iter_cnt_q  <= iter_cnt_d;
      ping_q      <= ping_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rewind_q    <= rewind_d;
      timeout_q   <= timeout_d;
      k_en_q      <= k_en_d;
      done_seen_q <= done_seen_d;
      settle_q    <= settle_d;
`ifdef SPMV_ITER_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign iter_cnt = iter_cnt_q;
  assign ping     = ping_q;
  assign rewind   = rewind_q;
  assign k_en     = k_en_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_spmv_iter_sequencer.sv
// Directed-vector bench for spmv_iter_sequencer; timeout expectations follow SPMV_ITER_TIMEOUT_EN.
module tb_spmv_iter_sequencer;
  localparam int NK = 4;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, cfg_en;
  logic [IW-1:0] num_iters;
  logic [NK-1:0] k_done;
  logic          busy, done, ping, rewind, timeout;
  logic [IW-1:0] iter_cnt;
  logic [NK-1:0] k_en;

  int n_vec = 0;
  int n_err = 0;
  int rew_total = 0, done_total = 0, busy_cyc = 0, ken_cyc = 0;
  int rew0, don0, busy0, ken0;

  spmv_iter_sequencer #(
    .NUM_KERNELS(NK), .ITER_W(IW), .PING_INIT(1'b0),
    .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_iters(num_iters),
    .abort(abort), .cfg_en(cfg_en), .busy(busy), .done(done),
    .iter_cnt(iter_cnt), .ping(ping), .rewind(rewind), .k_en(k_en),
    .k_done(k_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Pulse/activity counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rewind === 1'b1) rew_total <= rew_total + 1;
    if (done === 1'b1) done_total <= done_total + 1;
    if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
    if (|k_en) ken_cyc <= ken_cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    rew0 = rew_total; don0 = done_total; busy0 = busy_cyc; ken0 = ken_cyc;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_en = 1'b0;
    num_iters = '0; k_done = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    $display("txn reset");
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_rewind", rewind, 0);
    check_val("rst_ken", k_en, 0);
    check_val("rst_iter", iter_cnt, 0);
    check_val("rst_ping", ping, 0);
    check_val("rst_timeout", timeout, 0);

    // 1: one iteration, staggered lane completion at RUN cycles 5,9,9,20
    $display("txn single iteration, staggered lanes");
    snap();
    num_iters = 1; start = 1'b1;
    step(); start = 1'b0;
    check_val("s1_busy", busy, 1);
    check_val("s1_rewind", rewind, 1);
    check_val("s1_ken_launch", k_en, 4'hF);
    check_val("s1_ping0", ping, 0);
    for (int r = 1; r <= 20; r++) begin
      step();
      if (r == 1) check_val("s1_rewind_run", rewind, 0);
      check_val("s1_ken", k_en, (r <= 5) ? 4'hF : (r <= 9) ? 4'hE : 4'h8);
      k_done = '0;
      if (r == 5) k_done[0] = 1'b1;
      if (r == 9) k_done[2:1] = 2'b11;
      if (r == 20) k_done[3] = 1'b1;
    end
    step(); k_done = '0;
    check_val("s1_ken_off", k_en, 0);
    check_val("s1_iter", iter_cnt, 1);
    check_val("s1_ping1", ping, 1);
    check_val("s1_done_early", done, 0);
    step();
    check_val("s1_done", done, 1);
    check_val("s1_busy_off", busy, 0);
    step();
    check_val("s1_done_pulse", done, 0);
    check_val("s1_rew_count", rew_total - rew0, 1);
    check_val("s1_done_count", done_total - don0, 1);

    // 2: three iterations, all lanes done at RUN cycle 5 -> launches 8 cycles apart
    $display("txn three iterations");
    snap();
    num_iters = 3; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("s2_rewind", rewind, 1);
      check_val("s2_ping_launch", ping, i % 2);
      check_val("s2_iter_launch", iter_cnt, i);
      check_val("s2_ken_launch", k_en, 4'hF);
      for (int r = 1; r <= 5; r++) begin
        step();
        if (r == 5) k_done = '1;
      end
      step(); k_done = '0;
      check_val("s2_iter", iter_cnt, i + 1);
      check_val("s2_ping", ping, (i + 1) % 2);
      check_val("s2_ken_off", k_en, 0);
      if (i < 2) begin
        step();
        check_val("s2_settle_rew", rewind, 0);
        check_val("s2_settle_ken", k_en, 0);
        step();
      end
    end
    check_val("s2_finish_done", done, 0);
    step();
    check_val("s2_done", done, 1);
    check_val("s2_busy_off", busy, 0);
    check_val("s2_iter_final", iter_cnt, 3);
    step();
    check_val("s2_rew_count", rew_total - rew0, 3);
    check_val("s2_done_count", done_total - don0, 1);

    // 3: zero iterations
    $display("txn zero iterations");
    snap();
    num_iters = 0; start = 1'b1;
    step(); start = 1'b0;
    check_val("s3_done", done, 1);
    check_val("s3_busy", busy, 0);
    check_val("s3_iter", iter_cnt, 0);
    step();
    check_val("s3_done_pulse", done, 0);
    step(); step();
    check_val("s3_rew_count", rew_total - rew0, 0);
    check_val("s3_busy_cyc", busy_cyc - busy0, 0);
    check_val("s3_ken_cyc", ken_cyc - ken0, 0);
    check_val("s3_done_count", done_total - don0, 1);

    // 4: cfg_en blocks start; start during RUN ignored
    $display("txn cfg_en block and start while running");
    num_iters = 2; start = 1'b1; cfg_en = 1'b1;
    step(); start = 1'b0; cfg_en = 1'b0;
    check_val("s4_cfg_busy", busy, 0);
    check_val("s4_cfg_rewind", rewind, 0);
    step();
    check_val("s4_cfg_busy2", busy, 0);
    num_iters = 1; start = 1'b1;
    step(); start = 1'b0;
    check_val("s4_busy", busy, 1);
    check_val("s4_rewind", rewind, 1);
    check_val("s4_ping_init", ping, 0);
    step(); step();
    num_iters = 5; start = 1'b1;
    step(); start = 1'b0;
    check_val("s4_restart_rew", rewind, 0);
    check_val("s4_restart_busy", busy, 1);
    k_done = '1;
    step(); k_done = '0;
    check_val("s4_iter", iter_cnt, 1);
    step();
    check_val("s4_done", done, 1);
    step();
    check_val("s4_done_pulse", done, 0);
    check_val("s4_busy_off", busy, 0);

    // 5: abort in iteration 2 of 5, colliding with completion
    $display("txn abort in iteration 2");
    num_iters = 5; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    k_done = '1;
    step(); k_done = '0;
    check_val("s5_iter1", iter_cnt, 1);
    step(); step();
    check_val("s5_rewind2", rewind, 1);
    step(); step();
    snap();
    abort = 1'b1; k_done = '1;
    step(); abort = 1'b0; k_done = '0;
    check_val("s5_ken", k_en, 0);
    check_val("s5_busy", busy, 0);
    check_val("s5_iter", iter_cnt, 1);
    check_val("s5_ping", ping, 1);
    step(); step(); step();
    check_val("s5_done_count", done_total - don0, 0);
    check_val("s5_idle_busy", busy, 0);
    check_val("s5_idle_ken", k_en, 0);
    num_iters = 1; start = 1'b1;
    step(); start = 1'b0;
    check_val("s5_new_iter", iter_cnt, 0);
    check_val("s5_new_busy", busy, 1);
    check_val("s5_new_ping", ping, 0);
    step(); k_done = '1;
    step(); k_done = '0;
    check_val("s5_new_iter1", iter_cnt, 1);
    step();
    check_val("s5_new_done", done, 1);
    step();

    // 6: reset in the middle of a run
    $display("txn reset mid-run");
    num_iters = 2; start = 1'b1;
    step(); start = 1'b0;
    step(); k_done = '1;
    step(); k_done = '0;
    check_val("s6_iter_pre", iter_cnt, 1);
    snap();
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    check_val("s6_busy", busy, 0);
    check_val("s6_ken", k_en, 0);
    check_val("s6_iter", iter_cnt, 0);
    check_val("s6_ping", ping, 0);
    step(); step(); step();
    check_val("s6_done_count", done_total - don0, 0);
    check_val("s6_rew_count", rew_total - rew0, 0);

    // 7: lane 2 never finishes
    $display("txn lane 2 stuck");
    snap();
    num_iters = 1; start = 1'b1;
    step(); start = 1'b0;
    step(); k_done = 4'b1011;
    step(); k_done = '0;
    check_val("s7_ken_pending", k_en, 4'b0100);
    for (int r = 3; r <= 16; r++) step();
    check_val("s7_timeout_pre", timeout, 0);
    check_val("s7_busy_pre", busy, 1);
    step();
`ifdef SPMV_ITER_TIMEOUT_EN
    check_val("s7_timeout", timeout, 1);
    check_val("s7_busy", busy, 0);
    check_val("s7_ken", k_en, 0);
    step(); step();
    check_val("s7_timeout_sticky", timeout, 1);
    check_val("s7_done_count", done_total - don0, 0);
    num_iters = 1; start = 1'b1;
    step(); start = 1'b0;
    check_val("s7_timeout_clr", timeout, 0);
    check_val("s7_rerun_busy", busy, 1);
    step(); k_done = '1;
    step(); k_done = '0;
    step();
    check_val("s7_rerun_done", done, 1);
`else
    check_val("s7_timeout", timeout, 0);
    check_val("s7_busy", busy, 1);
    check_val("s7_ken", k_en, 4'b0100);
    abort = 1'b1;
    step(); abort = 1'b0;
    check_val("s7_abort_busy", busy, 0);
    check_val("s7_abort_ken", k_en, 0);
    check_val("s7_abort_timeout", timeout, 0);
    step();
    check_val("s7_done_count", done_total - don0, 0);
`endif
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
